// File: rtl/vec_mac_if.sv
// Job, operand and result bundle for the vec_mac dot-product engine.
// master drives jobs and operands and takes results; slave is the engine.
interface vec_mac_if #(
    parameter int A_BITWIDTH   = 8,
    parameter int B_BITWIDTH   = A_BITWIDTH,
    parameter int LEN_BITWIDTH = 8,
    parameter int OUT_BITWIDTH = 20,
    parameter int C_BITWIDTH   = OUT_BITWIDTH - 1
);
    logic                           start;
    logic        [LEN_BITWIDTH-1:0] len;
    logic signed [C_BITWIDTH-1:0]   bias;
    logic                           busy;

    logic                           in_valid;
    logic                           in_ready;
    logic signed [A_BITWIDTH-1:0]   in_a;
    logic signed [B_BITWIDTH-1:0]   in_b;

    logic                           out_valid;
    logic                           out_ready;
    logic signed [OUT_BITWIDTH-1:0] out_data;
    logic                           ovf;

    modport master (
        output start, len, bias, in_valid, in_a, in_b, out_ready,
        input  busy, in_ready, out_valid, out_data, ovf
    );

    modport slave (
        input  start, len, bias, in_valid, in_a, in_b, out_ready,
        output busy, in_ready, out_valid, out_data, ovf
    );
endinterface

// File: rtl/vec_mac.sv
// Sequential signed dot-product engine: accumulates len products, adds bias, saturates.
// Define VEC_MAC_RELU_EN to clamp negative saturated results to zero.
module vec_mac #(
    parameter int A_BITWIDTH   = 8,
    parameter int B_BITWIDTH   = A_BITWIDTH,
    parameter int LEN_BITWIDTH = 8,
    parameter int ACC_BITWIDTH = A_BITWIDTH + B_BITWIDTH + LEN_BITWIDTH,
    parameter int OUT_BITWIDTH = 20,
    parameter int C_BITWIDTH   = OUT_BITWIDTH - 1
) (
    input  logic        clk,
    input  logic        rstn,
    vec_mac_if.slave    bus
);
    localparam int PROD_W = A_BITWIDTH + B_BITWIDTH;
    localparam int SUM_W  = ACC_BITWIDTH + 1;

    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W - OUT_BITWIDTH + 1){1'b0}}, {(OUT_BITWIDTH - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W - OUT_BITWIDTH + 1){1'b1}}, {(OUT_BITWIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;

    state_t                         state, state_next;
    logic signed [ACC_BITWIDTH-1:0] acc;
    logic        [LEN_BITWIDTH-1:0] count;
    logic        [LEN_BITWIDTH-1:0] len_q;
    logic signed [C_BITWIDTH-1:0]   bias_q;

    logic signed [PROD_W-1:0]       prod;
    logic signed [SUM_W-1:0]        sum;
    logic signed [OUT_BITWIDTH-1:0] sat_result;
    logic signed [OUT_BITWIDTH-1:0] result;
    logic                           sat_ovf;
    logic                           in_fire;
    logic                           last_pair;

    assign in_fire   = bus.in_valid && bus.in_ready;
    assign last_pair = (count == len_q - LEN_BITWIDTH'(1));
    assign prod      = bus.in_a * bus.in_b;
    // One extra bit so acc + bias can never wrap before the clamp sees it.
    assign sum       = SUM_W'(acc) + SUM_W'(bias_q);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        sat_result = sum[OUT_BITWIDTH-1:0];
        sat_ovf    = 1'b0;
        if (sum > SAT_MAX) begin
            sat_result = SAT_MAX[OUT_BITWIDTH-1:0];
            sat_ovf    = 1'b1;
        end else if (sum < SAT_MIN) begin
            sat_result = SAT_MIN[OUT_BITWIDTH-1:0];
            sat_ovf    = 1'b1;
        end
    end

`ifdef VEC_MAC_RELU_EN
    assign result = sat_result[OUT_BITWIDTH-1] ? '0 : sat_result;
`else
    assign result = sat_result;
`endif

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = (bus.len != '0) ? ACCUM : BIAS;
            ACCUM:   if (in_fire && last_pair) state_next = BIAS;
            BIAS:    state_next = OUT;
            OUT:     if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state so they are registered yet cycle-exact.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            acc           <= '0;
            count         <= '0;
            len_q         <= '0;
            bias_q        <= '0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.ovf       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state         <= state_next;
            bus.busy      <= (state_next != IDLE);
            bus.in_ready  <= (state_next == ACCUM);
            bus.out_valid <= (state_next == OUT);
            unique case (state)
                IDLE: if (bus.start) begin
                    len_q  <= bus.len;
                    bias_q <= bus.bias;
                    acc    <= '0;
                    count  <= '0;
                end
                ACCUM: if (in_fire) begin
                    acc   <= acc + ACC_BITWIDTH'(prod);
                    count <= count + LEN_BITWIDTH'(1);
                end
                BIAS: begin
                    bus.out_data <= result;
                    bus.ovf      <= sat_ovf;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_mac.sv
// Scoreboard bench for vec_mac: expected results are queued at job start and
// popped when out_valid appears. Inputs are driven and outputs sampled on negedge.
module tb_vec_mac;
    localparam int A_W   = 8;
    localparam int B_W   = 8;
    localparam int LEN_W = 8;
    localparam int OUT_W = 20;
    localparam int C_W   = OUT_W - 1;
    localparam longint OMAX = (longint'(1) <<< (OUT_W - 1)) - 1;
    localparam longint OMIN = -(longint'(1) <<< (OUT_W - 1));

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    vec_mac_if bus ();
    vec_mac dut (.clk(clk), .rstn(rstn), .bus(bus));

    int   passed = 0;
    int   total  = 0;
    exp_t sb[$];
    int   pa[$];
    int   pb[$];

    function automatic exp_t model(input longint s, input longint b);
        exp_t   e;
        longint r = s + b;
        e.ovf = 1'b0;
        if (r > OMAX) begin r = OMAX; e.ovf = 1'b1; end
        else if (r < OMIN) begin r = OMIN; e.ovf = 1'b1; end
`ifdef VEC_MAC_RELU_EN
        if (r < 0) r = 0;
`endif
        e.data = r[OUT_W-1:0];
        return e;
    endfunction

    // Starts at a negedge, returns at the negedge of cycle 1.
    task automatic start_job(input int n, input longint b, input bit push);
        longint s = 0;
        for (int i = 0; i < n; i++) s += longint'(pa[i]) * longint'(pb[i]);
        if (push) sb.push_back(model(s, b));
        bus.start = 1'b1;
        bus.len   = LEN_W'(n);
        bus.bias  = C_W'(b);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Feeds pa/pb; returns at the first negedge with out_valid (ov_cycle = -1 on timeout).
    task automatic stream(input int n, input int gap, input bit pulse, input bit junk_after,
                          output int ov_cycle, output int extra);
        int idx = 0;
        int c   = 1;
        ov_cycle = -1;
        extra    = 0;
        repeat (2000) begin
            if (bus.out_valid) begin ov_cycle = c; break; end
            if (idx == n && bus.in_ready) extra++;
            if (idx < n && !(gap > 0 && c % gap == 0)) begin
                bus.in_valid = 1'b1;
                bus.in_a     = A_W'(pa[idx]);
                bus.in_b     = B_W'(pb[idx]);
                if (bus.in_ready) idx++;
            end else begin
                bus.in_valid = junk_after && (idx == n);
                bus.in_a     = A_W'(100);
                bus.in_b     = B_W'(100);
            end
            if (pulse) begin
                bus.start = (c % 3 == 0);
                bus.len   = LEN_W'(7);
                bus.bias  = C_W'(999);
            end
            @(negedge clk);
            c++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.busy, bus.in_ready, bus.out_valid, bus.ovf, bus.out_data} !== '0)
            $display("FAIL reset_outputs: busy=%b in_ready=%b out_valid=%b ovf=%b out_data=%0d, expected all 0",
                     bus.busy, bus.in_ready, bus.out_valid, bus.ovf, bus.out_data);
        else passed++;
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int ovc, ex;
        exp_t e;
        pa = '{1, 2, 3};
        pb = '{4, 5, 6};
        start_job(3, -10, 1'b1);
        total++;
        if (bus.in_ready !== 1'b1) $display("FAIL basic_in_ready_c1: got %b expected 1", bus.in_ready);
        else passed++;
        stream(3, 0, 1'b0, 1'b0, ovc, ex);
        e = sb.pop_front();
        total++;
        if (ovc !== 5) $display("FAIL basic_latency: out_valid at cycle %0d expected 5", ovc); else passed++;
        total++;
        if (bus.out_data !== e.data || e.data !== OUT_W'(22))
            $display("FAIL basic_data: got %0d expected 22", $signed(bus.out_data));
        else passed++;
        total++;
        if (bus.ovf !== 1'b0) $display("FAIL basic_ovf: got %b expected 0", bus.ovf); else passed++;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL basic_return_idle: out_valid=%b busy=%b expected 0 0", bus.out_valid, bus.busy);
        else passed++;
    endtask

    task automatic test_negative();
        int ovc, ex;
        exp_t e;
        pa = {};
        pb = {};
        start_job(0, -7, 1'b1);
        stream(0, 0, 1'b0, 1'b0, ovc, ex);
        e = sb.pop_front();
        total++;
        if (ovc !== 2) $display("FAIL neg_latency: out_valid at cycle %0d expected 2", ovc); else passed++;
        total++;
        if (bus.out_data !== e.data || bus.ovf !== e.ovf)
            $display("FAIL neg_data: got %0d/%b expected %0d/%b",
                     $signed(bus.out_data), bus.ovf, $signed(e.data), e.ovf);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int ovc, ex;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            pa = {};
            pb = {};
            for (int i = 0; i < 255; i++) begin
                pa.push_back(-128);
                pb.push_back(k == 0 ? -128 : 127);
            end
            start_job(255, 0, 1'b1);
            stream(255, 0, 1'b0, 1'b0, ovc, ex);
            e = sb.pop_front();
            total++;
            if (ovc !== 257) $display("FAIL sat%0d_latency: out_valid at cycle %0d expected 257", k, ovc);
            else passed++;
            total++;
            if (bus.out_data !== e.data)
                $display("FAIL sat%0d_data: got %0d expected %0d", k, $signed(bus.out_data), $signed(e.data));
            else passed++;
            total++;
            if (bus.ovf !== 1'b1) $display("FAIL sat%0d_ovf: got %b expected 1", k, bus.ovf); else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int ovc, ex;
        exp_t e;
        pa = '{2, 2, 2, 2};
        pb = '{3, 3, 3, 3};
        bus.out_ready = 1'b0;
        start_job(4, 0, 1'b1);
        stream(4, 2, 1'b1, 1'b1, ovc, ex);
        e = sb.pop_front();
        total++;
        if (ovc !== 9) $display("FAIL bp_latency: out_valid at cycle %0d expected 9", ovc); else passed++;
        total++;
        if (ex !== 0) $display("FAIL bp_in_ready_after_last: high for %0d cycles expected 0", ex); else passed++;
        for (int i = 0; i < 5; i++) begin
            bus.start = 1'b1;
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.ovf !== e.ovf || e.data !== OUT_W'(24))
                $display("FAIL bp_hold%0d: valid=%b data=%0d ovf=%b expected 1/24/0",
                         i, bus.out_valid, $signed(bus.out_data), bus.ovf);
            else passed++;
            @(negedge clk);
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL bp_no_queued_start: out_valid=%b busy=%b expected 0 0", bus.out_valid, bus.busy);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int ovc, ex;
        exp_t e;
        pa = '{4, 4, 4, 4, 4};
        pb = '{4, 4, 4, 4, 4};
        start_job(5, 0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = A_W'(pa[i]);
            bus.in_b     = B_W'(pb[i]);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.in_ready, bus.out_valid, bus.ovf, bus.out_data} !== '0)
            $display("FAIL midreset_outputs: busy=%b in_ready=%b out_valid=%b ovf=%b out_data=%0d, expected all 0",
                     bus.busy, bus.in_ready, bus.out_valid, bus.ovf, $signed(bus.out_data));
        else passed++;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        pa = '{3};
        pb = '{3};
        start_job(1, 1, 1'b1);
        stream(1, 0, 1'b0, 1'b0, ovc, ex);
        e = sb.pop_front();
        total++;
        if (ovc !== 3 || bus.out_data !== e.data || e.data !== OUT_W'(10))
            $display("FAIL midreset_newjob: cycle %0d data %0d expected cycle 3 data 10", ovc, $signed(bus.out_data));
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int ovc, ex, n;
        longint b;
        exp_t e;
        for (int j = 0; j < 4; j++) begin
            n  = int'($urandom_range(1, 6));
            b  = longint'($urandom_range(0, 2000)) - 1000;
            pa = {};
            pb = {};
            for (int i = 0; i < n; i++) begin
                pa.push_back(int'($urandom_range(0, 255)) - 128);
                pb.push_back(int'($urandom_range(0, 255)) - 128);
            end
            start_job(n, b, 1'b1);
            stream(n, 0, 1'b0, 1'b0, ovc, ex);
            e = sb.pop_front();
            total++;
            if (ovc !== n + 2 || bus.out_data !== e.data || bus.ovf !== e.ovf)
                $display("FAIL b2b_job%0d: cycle %0d data %0d ovf %b expected cycle %0d data %0d ovf %b",
                         j, ovc, $signed(bus.out_data), bus.ovf, n + 2, $signed(e.data), e.ovf);
            else passed++;
            @(negedge clk);
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.bias      = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        total++;
        if (sb.size() !== 0) $display("FAIL scoreboard_drained: %0d left expected 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/vec_mac.md
# vec_mac

Sequential signed dot-product engine: the parametrised successor to the single-shot multiply-accumulate cell. Per job it accepts a run-time length `len` and a bias, consumes `len` (a, b) operand pairs over a valid/ready stream, and accumulates their products at a configurable width. It then adds the bias, saturates to the output width and presents the result on a valid/ready output port. It sits between the operand fetch buffers and the result writeback in the convolution/FC datapath.

## Interface

- `A_BITWIDTH`, 8, signed width of operand a
- `B_BITWIDTH`, `A_BITWIDTH`, signed width of operand b
- `LEN_BITWIDTH`, 8, width of job length; max job = 2^LEN_BITWIDTH-1 pairs
- `ACC_BITWIDTH`, `A_BITWIDTH+B_BITWIDTH+LEN_BITWIDTH`, internal accumulator width (signed)
- `OUT_BITWIDTH`, 20, signed result width
- `C_BITWIDTH`, `OUT_BITWIDTH-1`, signed bias width
- `clk` in 1: clock, all state on rising edge
- `rstn` in 1: reset, asynchronous, active-low
- `start` in 1: job request, sampled only in IDLE
- `len` in LEN_BITWIDTH: number of pairs (unsigned), captured with `start`
- `bias` in C_BITWIDTH: signed bias, captured with `start`
- `busy` out 1: high in every state except IDLE
- `in_valid` in 1 / `in_ready` out 1: operand handshake
- `in_a` in A_BITWIDTH, `in_b` in B_BITWIDTH: signed operands, used only on an in handshake
- `out_valid` out 1 / `out_ready` in 1: result handshake
- `out_data` out OUT_BITWIDTH: signed result
- `ovf` out 1: result was saturated; valid while `out_valid`

## Operation

- States: IDLE, ACCUM, BIAS, OUT. Reset enters IDLE; acc, count, len/bias buffers = 0.
- IDLE: `in_ready`=0. On `start`=1, the block captures `len` and `bias` and clears acc and count. Next state is ACCUM if `len`≠0, else BIAS.
- ACCUM: `in_ready`=1. On each cycle with `in_valid`&&`in_ready`:
  - acc += sign-extended (in_a×in_b), full A+B-bit signed product;
  - count++.
  - On the handshake where count==len-1, go to BIAS with `in_ready` deasserted next cycle; no extra pair is accepted.
  - `in_valid` gaps stall the job without limit.
- BIAS: result = acc + sign-extended bias, computed at ACC_BITWIDTH+1 bits.
  - Clamp to [-2^(OUT_BITWIDTH-1), 2^(OUT_BITWIDTH-1)-1]; `ovf`=1 if clamped, else 0.
  - Register the result into `out_data` and go to OUT.
- OUT: `out_valid`=1. `out_data`/`ovf` are held stable until `out_ready`=1, then go to IDLE with `out_valid`=0 next cycle.
- Accumulator wraps two's-complement at ACC_BITWIDTH. This cannot occur with the default ACC_BITWIDTH.
- `start` outside IDLE is ignored: not queued, and captured values are unaffected. `in_valid` outside ACCUM is ignored.
- `rstn` low in any state aborts the job immediately. Partial accumulation is discarded and no result is emitted.

## Timing

- All outputs are registered. Reset values: `busy`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `ovf`=0.
- `start` sampled at edge 0:
  - ACCUM from cycle 1;
  - with continuous `in_valid`, pairs are consumed in cycles 1..len;
  - BIAS at cycle len+1;
  - `out_valid` rises at cycle len+2.
- `len`=0: BIAS at cycle 1, `out_valid` at cycle 2.
- Output handshake completes on the edge where `out_valid`&&`out_ready`. IDLE in the next cycle, so the next `start` is accepted at the earliest one cycle after the handshake.
- Throughput: one pair per cycle in ACCUM. Job overhead is 3 cycles (start, BIAS, OUT) with `out_ready` held high.

## Configuration

- `VEC_MAC_RELU_EN` defined: after saturation, a negative result is replaced by 0. `ovf` reflects saturation only, never the ReLU clamp.
- Not defined: the signed saturated result is output unchanged. No ReLU logic is synthesised.

## Test plan

- Basic job: len=3, bias=-10, pairs (1,4),(2,5),(3,6), `in_valid` and `out_ready` held high.
  - Expect `out_data`=22, `ovf`=0, `out_valid` at cycle 5.
- Negative result: len=0, bias=-7.
  - Expect `out_valid` at cycle 2 and `out_data`=-7 (0 with `VEC_MAC_RELU_EN`).
- Saturation: len=255, every pair (-128,-128), bias=0.
  - Sum 4177920 clamps to 524287 with `ovf`=1.
  - With a=-128, b=127 the result clamps to -524288 with `ovf`=1.
- Backpressure and stalls:
  - Insert `in_valid`=0 gaps in a len=4 job of (2,3) pairs.
  - Hold `out_ready`=0 for 5 cycles.
  - Expect `out_data`=24 stable throughout, `in_ready`=0 after the 4th pair, and `start` pulses during the job ignored.
- Reset mid-job: assert `rstn`=0 after 2 of 5 pairs.
  - All outputs return to reset values immediately.
  - A new job with len=1, (3,3), bias=1 then yields 10.
